// File: rtl/icg_latch_and.sv
// rtl/icg_latch_and.sv - latch-based glitch-free clock gate (negative-level enable latch plus AND)
module icg_latch_and (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clkg
);

    logic en_lat;

    // Transparent only while clk is low, so en can never reach clkg during the high phase.
    always_latch begin
        if (!rst) begin
            en_lat = 1'b0;
        end else if (!clk) begin
            en_lat = en;
        end
    end

    assign clkg = clk & en_lat;

endmodule

// File: rtl/clk_gating_cell.sv
// rtl/clk_gating_cell.sv - registers data on the free-running clock and on its gated copy
module clk_gating_cell #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic             clkg
);

    icg_latch_and u_icg (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clkg (clkg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1 <= '0;
        end else begin
            q1 <= data;
        end
    end

    // Gated-domain register; holds whenever the edge was suppressed by the latch.
    always_ff @(posedge clkg or negedge rst) begin
        if (!rst) begin
            q2 <= '0;
        end else begin
            q2 <= data;
        end
    end

endmodule

// File: tb/tb_clk_gating_cell.sv
// tb/tb_clk_gating_cell.sv - self-checking bench for clk_gating_cell
module tb_clk_gating_cell;

    localparam int W = 8;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         en   = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] q1;
    logic [W-1:0] q2;
    logic         clkg;

    int n_checks   = 0;
    int n_fail     = 0;
    int clkg_edges = 0;
    int glitches   = 0;
    int exp_edges  = 0;
    logic [W-1:0] exp_q1 = '0;
    logic [W-1:0] exp_q2 = '0;

    clk_gating_cell #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .data (data),
        .q1   (q1),
        .q2   (q2),
        .clkg (clkg)
    );

    always #5 clk = ~clk;

    always @(posedge clkg) clkg_edges++;

    // clk only ever changes on multiples of 5, so any clkg change off that grid is a glitch.
    always @(clkg) begin
        if (rst === 1'b1 && ($time % 5) != 0) glitches++;
    end

    // Reference model: one full clk cycle with en/data set in the low phase.
    task automatic step(input logic e, input logic [W-1:0] d);
        @(negedge clk);
        #1;
        en   = e;
        data = d;
        @(posedge clk);
        #1;
        exp_q1 = d;
        if (e) begin
            exp_q2 = d;
            exp_edges++;
        end
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        en   = 1'b1;
        data = W'(1);
        repeat (4) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (q1 !== '0) begin n_fail++; $display("FAIL reset_q1: got %h expected 00", q1); end
            n_checks++;
            if (q2 !== '0) begin n_fail++; $display("FAIL reset_q2: got %h expected 00", q2); end
            n_checks++;
            if (clkg !== 1'b0) begin n_fail++; $display("FAIL reset_clkg: got %b expected 0", clkg); end
        end
        n_checks++;
        if (clkg_edges !== 0) begin n_fail++; $display("FAIL reset_edges: got %0d expected 0", clkg_edges); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (q1 !== '0 || q2 !== '0 || clkg !== 1'b0) begin
            n_fail++; $display("FAIL release_nochange: q1 %h q2 %h clkg %b expected 00 00 0", q1, q2, clkg);
        end
        @(posedge clk);
        #1;
        exp_q1 = W'(1);
        exp_q2 = W'(1);
        exp_edges = 1;
        n_checks++;
        if (q1 !== exp_q1) begin n_fail++; $display("FAIL release_q1: got %h expected %h", q1, exp_q1); end
        n_checks++;
        if (q2 !== exp_q2) begin n_fail++; $display("FAIL release_q2: got %h expected %h", q2, exp_q2); end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL release_edges: got %0d expected %0d", clkg_edges, exp_edges); end
    endtask

    task automatic test_enabled;
        logic [W-1:0] pat [3];
        pat[0] = W'(1); pat[1] = W'(0); pat[2] = W'(1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pat[i]);
            n_checks++;
            if (q1 !== pat[i]) begin n_fail++; $display("FAIL enabled_q1[%0d]: got %h expected %h", i, q1, pat[i]); end
            n_checks++;
            if (q2 !== pat[i]) begin n_fail++; $display("FAIL enabled_q2[%0d]: got %h expected %h", i, q2, pat[i]); end
            n_checks++;
            if (clkg !== 1'b1) begin n_fail++; $display("FAIL enabled_clkg[%0d]: got %b expected 1", i, clkg); end
        end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL enabled_edges: got %0d expected %0d", clkg_edges, exp_edges); end
    endtask

    task automatic test_disabled;
        step(1'b1, W'(1));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, W'(i % 2));
            n_checks++;
            if (q1 !== W'(i % 2)) begin n_fail++; $display("FAIL disabled_q1[%0d]: got %h expected %h", i, q1, W'(i % 2)); end
            n_checks++;
            if (q2 !== W'(1)) begin n_fail++; $display("FAIL disabled_q2[%0d]: got %h expected 01", i, q2); end
            n_checks++;
            if (clkg !== 1'b0) begin n_fail++; $display("FAIL disabled_clkg[%0d]: got %b expected 0", i, clkg); end
        end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL disabled_edges: got %0d expected %0d", clkg_edges, exp_edges); end
    endtask

    task automatic test_glitch;
        step(1'b0, 8'h3c);
        en = 1'b1; #1; en = 1'b0; #1; en = 1'b1; #1;
        n_checks++;
        if (clkg !== 1'b0) begin n_fail++; $display("FAIL glitch_low_clkg: got %b expected 0", clkg); end
        step(1'b1, 8'h5a);
        n_checks++;
        if (q2 !== 8'h5a) begin n_fail++; $display("FAIL glitch_next_q2: got %h expected 5a", q2); end
        en = 1'b0; #1; en = 1'b1; #1; en = 1'b0; #1;
        n_checks++;
        if (clkg !== 1'b1) begin n_fail++; $display("FAIL glitch_high_clkg: got %b expected 1", clkg); end
        step(1'b0, 8'ha5);
        n_checks++;
        if (q2 !== 8'h5a) begin n_fail++; $display("FAIL glitch_suppress_q2: got %h expected 5a", q2); end
        n_checks++;
        if (glitches !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", glitches); end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL glitch_edges: got %0d expected %0d", clkg_edges, exp_edges); end
    endtask

    task automatic test_edge_align;
        step(1'b0, 8'h11);
        @(negedge clk);
        #1;
        data = 8'h22;
        @(posedge clk);
        en = 1'b1;
        #1;
        exp_q1 = 8'h22;
        n_checks++;
        if (clkg !== 1'b0) begin n_fail++; $display("FAIL align_clkg: got %b expected 0", clkg); end
        n_checks++;
        if (q2 !== exp_q2) begin n_fail++; $display("FAIL align_q2_hold: got %h expected %h", q2, exp_q2); end
        n_checks++;
        if (q1 !== exp_q1) begin n_fail++; $display("FAIL align_q1: got %h expected %h", q1, exp_q1); end
        @(negedge clk);
        #1;
        data = 8'h33;
        @(posedge clk);
        #1;
        exp_q1 = 8'h33;
        exp_q2 = 8'h33;
        exp_edges++;
        n_checks++;
        if (q2 !== exp_q2) begin n_fail++; $display("FAIL align_next_q2: got %h expected %h", q2, exp_q2); end
        n_checks++;
        if (clkg !== 1'b1) begin n_fail++; $display("FAIL align_next_clkg: got %b expected 1", clkg); end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL align_edges: got %0d expected %0d", clkg_edges, exp_edges); end
    endtask

    task automatic test_random;
        logic         e;
        logic [W-1:0] d;
        for (int i = 0; i < 40; i++) begin
            e = 1'($urandom_range(0, 1));
            d = W'($urandom);
            step(e, d);
            n_checks++;
            if (q1 !== exp_q1) begin n_fail++; $display("FAIL random_q1[%0d]: got %h expected %h", i, q1, exp_q1); end
            n_checks++;
            if (q2 !== exp_q2) begin n_fail++; $display("FAIL random_q2[%0d]: got %h expected %h", i, q2, exp_q2); end
            n_checks++;
            if (clkg !== e) begin n_fail++; $display("FAIL random_clkg[%0d]: got %b expected %b", i, clkg, e); end
        end
        n_checks++;
        if (clkg_edges !== exp_edges) begin n_fail++; $display("FAIL random_edges: got %0d expected %0d", clkg_edges, exp_edges); end
        n_checks++;
        if (glitches !== 0) begin n_fail++; $display("FAIL random_glitches: got %0d expected 0", glitches); end
    endtask

    task automatic test_async_reset;
        step(1'b1, W'(1));
        n_checks++;
        if (q1 !== W'(1) || q2 !== W'(1) || clkg !== 1'b1) begin
            n_fail++; $display("FAIL async_pre: q1 %h q2 %h clkg %b expected 01 01 1", q1, q2, clkg);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (q1 !== '0) begin n_fail++; $display("FAIL async_q1: got %h expected 00", q1); end
        n_checks++;
        if (q2 !== '0) begin n_fail++; $display("FAIL async_q2: got %h expected 00", q2); end
        n_checks++;
        if (clkg !== 1'b0) begin n_fail++; $display("FAIL async_clkg: got %b expected 0", clkg); end
        @(posedge clk);
        #1;
        n_checks++;
        if (clkg !== 1'b0 || q2 !== '0) begin
            n_fail++; $display("FAIL async_hold: clkg %b q2 %h expected 0 00", clkg, q2);
        end
    endtask

    initial begin
        test_reset();
        test_enabled();
        test_disabled();
        test_glitch();
        test_edge_align();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
